// File: rtl/fsqrt_table_loader_pkg.sv
// Shared constants and loader state encoding for the fsqrt slope/intercept table.
// The CHECK state exists only when FSQRT_TABLE_CHECKSUM_EN is defined.
package fsqrt_table_loader_pkg;

  localparam int FSQRT_TBL_DEPTH  = 1024;
  localparam int FSQRT_TBL_AW     = 10;
  localparam int FSQRT_TBL_DW     = 36;   // {slope[12:0], intercept[22:0]}
  localparam int FSQRT_TBL_NBYTES = 5;    // ceil(DW/8)

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_RECV  = 3'd1,
    LD_WRITE = 3'd2,
`ifdef FSQRT_TABLE_CHECKSUM_EN
    LD_CHECK = 3'd3,
`endif
    LD_DONE  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/fsqrt_table_loader.sv
// Byte-stream loader for the fsqrt table RAM: packs 5 bytes per word, writes 0..DEPTH-1.
// Optional trailing XOR checksum byte when FSQRT_TABLE_CHECKSUM_EN is defined.
module fsqrt_table_loader
  import fsqrt_table_loader_pkg::*;
#(
  parameter int DEPTH  = FSQRT_TBL_DEPTH,
  parameter int AW     = FSQRT_TBL_AW,
  parameter int DW     = FSQRT_TBL_DW,
  parameter int NBYTES = FSQRT_TBL_NBYTES
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          tbl_we,
  output logic [AW-1:0] tbl_waddr,
  output logic [DW-1:0] tbl_wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int BCW = $clog2(NBYTES);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  ld_state_e        state_q, state_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [AW:0]      addr_q, addr_d;
  logic [DW-1:0]    shreg_q, shreg_d;
  wr_t              wr_q, wr_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

`ifdef FSQRT_TABLE_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             err_q, err_d;
`endif

  assign accept = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    shreg_d = shreg_q;
    wr_d    = wr_q;
    wr_d.we = 1'b0;
`ifdef FSQRT_TABLE_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          state_d = LD_RECV;
          bcnt_d  = '0;
          addr_d  = '0;
`ifdef FSQRT_TABLE_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      LD_RECV: begin
        if (accept) begin
          // Bits shifted past DW fall off, which drops byte0[7:4].
          shreg_d = {shreg_q[DW-9:0], in_data};
`ifdef FSQRT_TABLE_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          if (bcnt_q == BCW'(NBYTES-1)) begin
            state_d    = LD_WRITE;
            wr_d.we    = 1'b1;
            wr_d.addr  = addr_q[AW-1:0];
            wr_d.data  = shreg_d;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      LD_WRITE: begin
        addr_d = addr_q + 1'b1;
        bcnt_d = '0;
        if (addr_q == (AW+1)'(DEPTH-1)) begin
`ifdef FSQRT_TABLE_CHECKSUM_EN
          state_d = LD_CHECK;
`else
          state_d = LD_DONE;
`endif
        end else begin
          state_d = LD_RECV;
        end
      end
`ifdef FSQRT_TABLE_CHECKSUM_EN
      LD_CHECK: begin
        if (accept) begin
          err_d   = (in_data != csum_q);
          state_d = LD_DONE;
        end
      end
`endif
      default: state_d = LD_IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
`ifdef FSQRT_TABLE_CHECKSUM_EN
    ready_d = (state_d == LD_RECV) || (state_d == LD_CHECK);
    busy_d  = (state_d == LD_RECV) || (state_d == LD_WRITE) || (state_d == LD_CHECK);
`else
    ready_d = (state_d == LD_RECV);
    busy_d  = (state_d == LD_RECV) || (state_d == LD_WRITE);
`endif
    done_d  = (state_d == LD_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LD_IDLE;
      bcnt_q  <= '0;
      addr_q  <= '0;
      shreg_q <= '0;
      wr_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      shreg_q <= shreg_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef FSQRT_TABLE_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = ready_q;
  assign tbl_we    = wr_q.we;
  assign tbl_waddr = wr_q.addr;
  assign tbl_wdata = wr_q.data;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
